nibble_serial_adder_ctrl: RTL and testbench

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

---
 rtl/nibble_serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder/subtractor: one shared 4-bit adder processes one nibble per clock, LSB first.
// Result, carry-out and signed overflow are registered and held until the next accepted start.

module four_bit_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);
    logic [4:0] total;

    assign total = 5'(a_i) + 5'(b_i) + 5'(ci_i);
    assign s_o   = total[3:0];
    assign co_o  = total[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic [W-1:0]  sum_d;
    logic          cout_q;
    logic          ovf_q;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    s_nib;
    logic          c_nib;
    logic          last_c;

    // Select the operand nibbles addressed by the index and merge the adder result back.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        sum_d = sum_q;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) begin
                a_nib          = a_q[n*4 +: 4];
                b_nib          = b_q[n*4 +: 4];
                sum_d[n*4 +: 4] = s_nib;
            end
        end
    end

    four_bit_adder u_add (
        .a_i  (a_nib),
        .b_i  (b_nib),
        .ci_i (carry_q),
        .s_o  (s_nib),
        .co_o (c_nib)
    );

    assign last_c = (idx_q == IW'(NIBBLES - 1));

    // b_q holds the already-inverted operand for subtraction, so its MSB is b_eff[W-1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {W{sub}};
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= c_nib;
                    idx_q   <= idx_q + IW'(1);
                    if (last_c) begin
                        state_q <= S_DONE;
                        cout_q  <= c_nib;
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (s_nib[3] != a_q[W-1]);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl: directed operations push expected results,
// a monitor pops and compares them whenever done is high.

module tb_nibble_serial_adder_ctrl;
    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One operation; with inject set, a conflicting start is held during RUN and must be ignored.
    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s, input logic c,
                      input logic [W-1:0] es, input logic ec, input logic eo, input bit inject);
        int n;
        int nb;
        bit seen;
        exp_t e;
        e.sum = es; e.cout = ec; e.ovf = eo;
        sb_q.push_back(e);
        @(negedge clk);
        a = av; b = bv; sub = s; cin = c; start = 1'b1;
        n = 0; nb = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            seen = done;
            if (n == 1) begin
                if (inject) begin
                    a = 16'hFFFF; b = 16'hFFFF;
                end else begin
                    start = 1'b0;
                end
            end
            if (n == 3) start = 1'b0;
        end
        check("done_timeout", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(NIB + 1));
        check("busy_cycles", 32'(nb), 32'(NIB));
    endtask

    // Monitor: compare every done cycle against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                check("busy_done_excl", 32'(busy), 32'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        int  n;
        bit  seen;
        exp_t e;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_sum", 32'(sum), 32'h8000);
        check("hold_ovf", 32'(ovf), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);

        op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Abort mid-RUN: asynchronous reset between edges, no done may follow.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

        op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);

        // Back-to-back: start held high through DONE.
        e.sum = 16'h0010; e.cout = 1'b0; e.ovf = 1'b0;
        sb_q.push_back(e);
        sb_q.push_back(e);
        @(negedge clk);
        a = 16'h000F; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = done;
        end
        check("b2b_first_latency", 32'(n), 32'(NIB + 1));
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            seen = done;
        end
        check("b2b_gap", 32'(n), 32'(NIB + 1));

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
